// File: rtl/y86_alu.sv
// y86_alu: Y86-64 execute-stage ALU with combinational flags and a registered condition-code copy
module y86_alu #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ctrl,
    input  logic             set_cc,
    output logic [WIDTH-1:0] ans,
    output logic [2:0]       cond,
    output logic [2:0]       cc_q
);
    logic             is_sub;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum;
    logic             of;

    // Shared adder: subtraction feeds ~b with a carry-in of one; overflow is judged on the adder's real operands
    always_comb begin
        is_sub = ctrl == 2'b01;
        b_in   = is_sub ? ~b : b;
        sum    = a + b_in + {{(WIDTH-1){1'b0}}, is_sub};
        ans    = ctrl[1] ? (ctrl[0] ? a ^ b : a & b) : sum;
        of     = !ctrl[1] && (a[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        cond   = {ans == '0, ans[WIDTH-1], of};
    end

    // Condition-code register: reset wins over set_cc, otherwise latch or hold
    always_ff @(posedge clock) begin
        if (!reset_n)
            cc_q <= 3'b000;
        else if (set_cc)
            cc_q <= cond;
    end
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: randomized and directed self-checking bench for y86_alu against an arithmetic reference model
module tb_y86_alu;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [1:0]  ctrl = 2'b00;
    logic        set_cc = 1'b0;
    logic [63:0] ans;
    logic [2:0]  cond;
    logic [2:0]  cc_q;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [2:0]  cc_model = 3'b000;
    logic [63:0] corners [6] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h2A};

    y86_alu #(.WIDTH(64)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .a      (a),
        .b      (b),
        .ctrl   (ctrl),
        .set_cc (set_cc),
        .ans    (ans),
        .cond   (cond),
        .cc_q   (cc_q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: exact signed math on 66 bits; overflow means the true result does not fit in 64 bits
    function automatic logic [66:0] ref_alu(input logic [63:0] x, input logic [63:0] y, input logic [1:0] op);
        logic signed [65:0] sx, sy, full;
        logic [63:0]        r;
        logic               ovf;
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        case (op)
            2'b00:   full = sx + sy;
            2'b01:   full = sx - sy;
            2'b10:   full = {2'b00, x & y};
            default: full = {2'b00, x ^ y};
        endcase
        r   = full[63:0];
        ovf = (op < 2'd2) && (full != {{2{r[63]}}, r});
        return {r, r == 64'h0, r[63], ovf};
    endfunction

    task automatic apply(input logic [63:0] av, input logic [63:0] bv, input logic [1:0] c,
                         input logic s, input logic rn);
        logic [66:0] e;
        @(negedge clock);
        a = av; b = bv; ctrl = c; set_cc = s; reset_n = rn;
        e = ref_alu(av, bv, c);
        #1;
        check("ans", ans, e[66:3]);
        check("cond", {61'h0, cond}, {61'h0, e[2:0]});
        @(posedge clock);
        cc_model = !rn ? 3'b000 : (s ? e[2:0] : cc_model);
        #1;
        check("cc_q", {61'h0, cc_q}, {61'h0, cc_model});
    endtask

    function automatic logic [63:0] pick();
        return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] ra, rb;
        apply(64'd5, 64'd7, 2'b00, 1'b0, 1'b0);
        check("cc_reset", {61'h0, cc_q}, 64'h0);
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b1);
        check("add_ovf_cond", {61'h0, cond}, 64'h3);
        apply(64'd3, 64'd10, 2'b01, 1'b0, 1'b1);
        check("sub_neg_ans", ans, 64'hFFFF_FFFF_FFFF_FFF9);
        apply(64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b0, 1'b1);
        check("sub_ovf_cond", {61'h0, cond}, 64'h1);
        apply(64'hF0F0, 64'h0FF0, 2'b10, 1'b0, 1'b1);
        apply(64'h1234, 64'h1234, 2'b11, 1'b0, 1'b1);
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 1'b0, 1'b1);
        apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0, 1'b1);
        check("wrap_cond", {61'h0, cond}, 64'h4);
        apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, 1'b1);
        apply(64'd42, 64'd42, 2'b01, 1'b1, 1'b1);
        check("cc_latch", {61'h0, cc_q}, 64'h4);
        apply(64'd5, 64'd7, 2'b00, 1'b0, 1'b1);
        check("cc_hold", {61'h0, cc_q}, 64'h4);
        apply(64'd5, 64'd7, 2'b00, 1'b1, 1'b1);
        check("cc_update", {61'h0, cc_q}, 64'h0);
        apply(64'd42, 64'd42, 2'b01, 1'b1, 1'b1);
        apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1, 1'b0);
        check("rst_prio", {61'h0, cc_q}, 64'h0);
        check("rst_live_ans", ans, 64'h8000_0000_0000_0000);
        for (int i = 0; i < 300; i++) begin
            ra = pick();
            rb = ($urandom_range(0, 7) == 0) ? ra : pick();
            apply(ra, rb, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
